cfg_commit_sequencer: RTL
=========================

Name: cfg_commit_sequencer

Overview:
- Command-stream controller that drives the 2x8 ping-pong {index, gain} config bank.
- Accepts 32-bit command words over a valid/ready stream from the host register or AXIS bridge.
- Turns each word into a single-cycle index or gain write strobe into the shadow bank, or into a commit request.
- Holds the commit request until the datapath signals a safe boundary, verifies the bank flip, and blocks new writes while a commit is outstanding.

Parameters:
- IDX_W, 10, index field width (1..26)
- GAIN_W, 18, gain field width (1..26)
- TIMEOUT_CYC, 65535, max cycles commit_req waits for commit_safe before abort (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  command word valid
- s_ready  out  1  sequencer can accept a word
- s_data  in  32  command word. [31:30] op (00 idx write, 01 gain write, 10 commit, 11 clear status); [29] ch (0 A, 1 B); [28:26] tone; [25:0] payload, low IDX_W/GAIN_W bits used
- idx_we  out  1  one-cycle index write strobe
- gain_we  out  1  one-cycle gain write strobe
- wr_ch  out  1  channel for current strobe
- wr_tone  out  3  tone for current strobe
- wr_index  out  IDX_W  index payload
- wr_gain  out  GAIN_W  gain payload
- commit_req  out  1  commit request to bank
- commit_safe  in  1  datapath boundary; the bank flips on commit_req && commit_safe
- active_bank  in  1  current active bank from the config bank
- busy  out  1  commit outstanding (state != IDLE)
- pending_writes  out  8  writes since last completed commit, saturates at 255
- commit_cnt  out  16  completed commits, wraps
- err_timeout  out  1  sticky: a commit aborted on timeout
- err_noflip  out  1  sticky: active_bank failed to flip after a commit handshake

Behaviour:
- Reset, synchronous on rst=1: state=IDLE; every output 0 except s_ready=1. This covers strobes, wr_* fields, commit_req, counters and error flags. Reset mid-commit drops commit_req on the next edge.
- States: IDLE, WAIT_SAFE, CHECK.
- A word is accepted on any edge with s_valid && s_ready. s_ready = (state==IDLE).
- IDLE, op 00/01, accepted at edge N:
  - idx_we (or gain_we) =1 for exactly the cycle after N.
  - wr_ch, wr_tone and the payload are registered at N and held until the next accepted write.
  - wr_index takes s_data[IDX_W-1:0]; wr_gain takes s_data[GAIN_W-1:0]. Bits above the field width are ignored.
  - Back-to-back writes sustain 1 word/cycle.
  - pending_writes +1, saturating at 255.
- IDLE, op 10, accepted at edge N:
  - Sample expected = ~active_bank.
  - commit_req=1 from cycle N+1; go to WAIT_SAFE; clear the timeout counter.
- IDLE, op 11: clear err_timeout, err_noflip and pending_writes. No strobe; stay in IDLE.
- WAIT_SAFE:
  - On an edge with commit_safe=1: commit_req=0 next cycle; go to CHECK.
  - Else increment the timeout counter. At TIMEOUT_CYC without safe: commit_req=0, err_timeout=1, go to IDLE. pending_writes and commit_cnt are unchanged.
  - commit_safe at the first cycle of commit_req completes the handshake in that cycle (1-cycle commit_req).
- CHECK (one cycle):
  - If active_bank==expected: commit_cnt +1, pending_writes=0.
  - Else err_noflip=1; counters unchanged.
  - Then IDLE.
- No write strobe is ever asserted in a cycle where commit_req=1; writes cannot race the bank flip.
- commit_req never asserts during CHECK, so one op 10 produces exactly one flip.
- Write strobes and commit_req are registered outputs; no combinational path from s_data to strobes.
- s_ready is combinational from state only; it has no dependency on s_valid.
- A commit with pending_writes=0 is still issued; the bank flips normally.

Test Plan:
- Reset: drive rst=1 for 2 cycles with s_valid=1 -> all strobes 0, commit_req 0, s_ready 1, counters 0; no word accepted.
- Write stream: op00 ch0 tone3 idx 0x155, then op01 ch1 tone7 gain 0x10000, back-to-back -> idx_we pulse with wr_tone=3, wr_index=0x155, then gain_we pulse with wr_ch=1, wr_gain=0x10000 the next cycle; pending_writes=2.
- Commit with delayed safe: op10, commit_safe held 0 for 5 cycles then 1, with the bank model flipping -> commit_req high exactly 6 cycles; s_ready low until CHECK ends; commit_cnt=1, pending_writes=0, no write strobes during the window.
- Immediate safe: op10 with commit_safe=1 constant -> commit_req high 1 cycle, one bank flip, commit_cnt increments by 1.
- Timeout: TIMEOUT_CYC=8, commit_safe=0 -> commit_req drops after 8 cycles, err_timeout=1, commit_cnt unchanged, s_ready=1; then op11 -> err_timeout=0.
- No-flip and reset mid-commit: bank model ignores the flip -> err_noflip=1. Assert rst during WAIT_SAFE -> commit_req 0 on the next edge; state IDLE.

Source files
------------

// File: rtl/cfg_commit_sequencer_if.sv
// cfg_commit_sequencer_if: 32-bit command word valid/ready stream
interface cfg_commit_sequencer_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    modport master (output s_valid, output s_data, input s_ready);
    modport slave (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/cfg_commit_sequencer.sv
// cfg_commit_sequencer: turns command words into shadow-bank write strobes and guarded commit handshakes
module cfg_commit_sequencer #(
    parameter int IDX_W       = 10,
    parameter int GAIN_W      = 18,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    cfg_commit_sequencer_if.slave cmd,
    output logic                  idx_we,
    output logic                  gain_we,
    output logic                  wr_ch,
    output logic [2:0]            wr_tone,
    output logic [IDX_W-1:0]      wr_index,
    output logic [GAIN_W-1:0]     wr_gain,
    output logic                  commit_req,
    input  logic                  commit_safe,
    input  logic                  active_bank,
    output logic                  busy,
    output logic [7:0]            pending_writes,
    output logic [15:0]           commit_cnt,
    output logic                  err_timeout,
    output logic                  err_noflip
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, WAIT_SAFE, CHECK} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tcnt;
    logic          expected;
    logic          acc;
    logic [1:0]    op;
    logic          tmo;
    logic          unused_bits;

    assign acc         = cmd.s_valid && cmd.s_ready;
    assign op          = cmd.s_data[31:30];
    assign tmo         = tcnt == TW'(TIMEOUT_CYC - 1);
    assign unused_bits = ^cmd.s_data[25:0];

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: a commit word opens the handshake, safe or timeout closes it
    always_comb begin
        state_nx = (state == IDLE)      ? ((acc && op == 2'b10) ? WAIT_SAFE : IDLE) :
                   (state == WAIT_SAFE) ? (commit_safe ? CHECK : (tmo ? IDLE : WAIT_SAFE)) :
                                          IDLE;
    end

    // state-decoded outputs; commit_req is high only while waiting for the boundary
    always_comb begin
        cmd.s_ready = state == IDLE;
        busy        = state != IDLE;
        commit_req  = state == WAIT_SAFE;
    end

    // write strobes, write fields, timeout counter, bank-flip check and status counters
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_we         <= 1'b0;
            gain_we        <= 1'b0;
            wr_ch          <= 1'b0;
            wr_tone        <= '0;
            wr_index       <= '0;
            wr_gain        <= '0;
            pending_writes <= '0;
            commit_cnt     <= '0;
            err_timeout    <= 1'b0;
            err_noflip     <= 1'b0;
            expected       <= 1'b0;
            tcnt           <= '0;
        end else begin
            idx_we  <= acc && op == 2'b00;
            gain_we <= acc && op == 2'b01;
            if (acc && !op[1]) begin
                wr_ch          <= cmd.s_data[29];
                wr_tone        <= cmd.s_data[28:26];
                pending_writes <= (pending_writes == 8'hff) ? pending_writes : pending_writes + 8'd1;
                if (op[0]) wr_gain  <= cmd.s_data[GAIN_W-1:0];
                else       wr_index <= cmd.s_data[IDX_W-1:0];
            end
            if (acc && op == 2'b10) begin
                expected <= ~active_bank;
                tcnt     <= '0;
            end
            if (acc && op == 2'b11) begin
                err_timeout    <= 1'b0;
                err_noflip     <= 1'b0;
                pending_writes <= '0;
            end
            if (state == WAIT_SAFE && !commit_safe) begin
                tcnt <= tcnt + TW'(1);
                if (tmo) err_timeout <= 1'b1;
            end
            if (state == CHECK) begin
                if (active_bank == expected) begin
                    commit_cnt     <= commit_cnt + 16'd1;
                    pending_writes <= '0;
                end else begin
                    err_noflip <= 1'b1;
                end
            end
        end
    end
endmodule
